// File: rtl/lsu_pkg.sv
// lsu_pkg: shared states, funct3 codes, byte-enable masks and access classification for lsu_bus_if
package lsu_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    return f3 == F3_B || f3 == F3_H || f3 == F3_W || (!we && (f3 == F3_BU || f3 == F3_HU));
  endfunction
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    return (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00);
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte enables, store lane replication and load lane extraction/extension
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  be,
  output logic [31:0] swdata,
  output logic [31:0] xrdata
);
  logic [7:0] b;
  logic [15:0] h;
  logic sx;
  always_comb begin
    b = bus_rdata[{addr, 3'b000} +: 8];
    h = addr[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    sx = ~funct3[2];
    be = funct3[1:0] == 2'b00 ? BE_BYTE << addr : funct3[1:0] == 2'b01 ? BE_HALF << {addr[1], 1'b0} : BE_WORD;
    swdata = funct3[1:0] == 2'b00 ? {4{wdata[7:0]}} : funct3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
    xrdata = funct3[1:0] == 2'b00 ? {{24{b[7] & sx}}, b} : funct3[1:0] == 2'b01 ? {{16{h[15] & sx}}, h} : bus_rdata;
  end
endmodule

// File: rtl/lsu_bus_if.sv
// lsu_bus_if: load/store request/ready bus interface with timeout and extended load data
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses end with err and no bus cycle.
module lsu_bus_if
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_ready
);
  state_t state;
  logic we_q;
  logic [2:0] f3_q;
  logic [1:0] a_q;
  logic [7:0] cnt;
  logic [3:0] be;
  logic [31:0] swdata, xrdata;
  logic reject;
  // Idle uses the live request fields; afterwards the latched ones drive load extraction.
  lsu_align u_align (
    .funct3   (state == IDLE ? funct3 : f3_q),
    .addr     (state == IDLE ? addr[1:0] : a_q),
    .wdata    (wdata),
    .bus_rdata(bus_rdata),
    .be       (be),
    .swdata   (swdata),
    .xrdata   (xrdata)
  );
`ifdef MISALIGN_TRAP_EN
  assign reject = !f3_legal(we, funct3) || misaligned(funct3, addr[1:0]);
`else
  assign reject = !f3_legal(we, funct3);
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rdata <= '0;
      done <= 1'b0;
      err <= 1'b0;
      busy <= 1'b0;
      bus_req <= 1'b0;
      bus_we <= 1'b0;
      bus_addr <= '0;
      bus_be <= '0;
      bus_wdata <= '0;
      cnt <= '0;
      we_q <= 1'b0;
      f3_q <= '0;
      a_q <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          busy <= 1'b1;
          rdata <= '0;
          cnt <= '0;
          we_q <= we;
          f3_q <= funct3;
          a_q <= addr[1:0];
          err <= reject;
          done <= reject;
          state <= reject ? RESP : REQ;
          bus_req <= !reject;
          if (!reject) begin
            bus_we <= we;
            bus_addr <= {addr[ADDR_W-1:2], 2'b00};
            bus_be <= be;
            bus_wdata <= swdata;
          end
        end
        REQ: if (bus_ready || cnt == 8'(TIMEOUT - 1)) begin
          state <= RESP;
          done <= 1'b1;
          bus_req <= 1'b0;
          err <= !bus_ready;
          if (bus_ready && !we_q) rdata <= xrdata;
        end else cnt <= cnt + 8'd1;
        RESP: begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_bus_if.sv
// tb_lsu_bus_if: directed and random accesses checked against a behavioural byte-lane model
module tb_lsu_bus_if;
  localparam int TIMEOUT = 16;
  logic clk = 0, reset = 1, start = 0, we = 0, bus_ready = 0;
  logic [2:0] funct3 = 0;
  logic [31:0] addr = 0, wdata = 0, bus_rdata = 0;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic done, err, busy, bus_req, bus_we;
  logic [3:0] bus_be;
  int total = 0, bad = 0;

  lsu_bus_if #(.ADDR_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .we(we), .funct3(funct3), .addr(addr),
    .wdata(wdata), .rdata(rdata), .done(done), .err(err), .busy(busy), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ready(bus_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int size_of(input bit [2:0] f3);
    return f3[1:0] == 0 ? 1 : f3[1:0] == 1 ? 2 : 4;
  endfunction

  // A naturally aligned lane offset: low address bits rounded down to the access size.
  function automatic int off_of(input bit [2:0] f3, input bit [31:0] ad);
    return (ad % 4) / size_of(f3) * size_of(f3);
  endfunction

  function automatic bit [31:0] m_be(input bit [2:0] f3, input bit [31:0] ad);
    return ((1 << size_of(f3)) - 1) << off_of(f3, ad);
  endfunction

  function automatic bit [31:0] m_wdata(input bit [2:0] f3, input bit [31:0] wd);
    bit [31:0] r = 0;
    for (int i = 0; i < 4; i++) r |= ((wd >> (8 * (i % size_of(f3)))) & 32'hFF) << (8 * i);
    return r;
  endfunction

  function automatic bit [31:0] m_load(input bit [2:0] f3, input bit [31:0] ad, input bit [31:0] rd);
    int sz = size_of(f3);
    longint v;
    if (sz == 4) return rd;
    v = (rd >> (8 * off_of(f3, ad))) & ((64'd1 << (8 * sz)) - 1);
    if (f3 < 4 && v >= (64'd1 << (8 * sz - 1))) v -= 64'd1 << (8 * sz);
    return 32'(v);
  endfunction

  function automatic bit m_goes(input bit w, input bit [2:0] f3, input bit [31:0] ad);
    bit ok = f3 <= 2 || (!w && (f3 == 4 || f3 == 5));
`ifdef MISALIGN_TRAP_EN
    if ((size_of(f3) == 2 && ad[0]) || (size_of(f3) == 4 && ad[1:0] != 0)) ok = 0;
`endif
    return ok;
  endfunction

  task automatic access(input bit w, input bit [2:0] f3, input bit [31:0] ad, input bit [31:0] wd,
                        input bit [31:0] rd, input int waits, input bit never);
    int lat = never ? TIMEOUT : waits + 1;
    we = w; funct3 = f3; addr = ad; wdata = wd; start = 1;
    step();
    start = 0;
    chk("busy_after_start", busy, 1);
    if (!m_goes(w, f3, ad)) begin
      chk("rej_no_req", bus_req, 0);
      chk("rej_done", done, 1);
      chk("rej_err", err, 1);
      chk("rej_rdata", rdata, 0);
    end else begin
      chk("bus_addr", bus_addr, ad & ~32'd3);
      chk("bus_be", bus_be, m_be(f3, ad));
      chk("bus_we", bus_we, w);
      if (w) chk("bus_wdata", bus_wdata, m_wdata(f3, wd));
      for (int i = 0; i < lat; i++) begin
        chk("req_wait", {bus_req, busy, done}, 3'b110);
        bus_ready = !never && i == waits;
        bus_rdata = bus_ready ? rd : $urandom;
        start = $urandom_range(0, 1);
        addr = $urandom;
        step();
        start = 0;
      end
      bus_ready = 0;
      chk("done", {done, busy, bus_req}, 3'b110);
      chk("err", err, never);
      if (!w) chk("rdata", rdata, never ? 0 : m_load(f3, ad, rd));
    end
    step();
    chk("idle_after", {done, busy, bus_req}, 3'b000);
    if (!w) chk("rdata_held", rdata, (!m_goes(w, f3, ad) || never) ? 0 : m_load(f3, ad, rd));
  endtask

  initial begin
    step();
    step();
    chk("rst_outs", {done, err, busy, bus_req, bus_we, bus_be}, 0);
    chk("rst_data", rdata | bus_addr | bus_wdata, 0);
    reset = 0;
    step();
    access(1, 3'b000, 32'h103, 32'h000000A5, 0, 0, 0);
    access(0, 3'b000, 32'h202, 0, 32'h12F45678, 0, 0);
    access(0, 3'b100, 32'h202, 0, 32'h12F45678, 1, 0);
    access(0, 3'b001, 32'h006, 0, 32'h80017FFF, 0, 0);
    access(0, 3'b010, 32'h40, 0, 32'hDEADBEEF, 5, 0);
    access(0, 3'b010, 32'h44, 0, 32'h0, 0, 1);
    access(0, 3'b011, 32'h48, 0, 32'h0, 0, 0);
    access(1, 3'b100, 32'h4C, 32'h1234, 32'h0, 0, 0);
    access(1, 3'b010, 32'h101, 32'hCAFEF00D, 32'h0, 0, 0);
    access(0, 3'b101, 32'h3, 0, 32'h8001FFFE, 2, 0);
    // Reset while a request is outstanding aborts silently.
    we = 0; funct3 = 3'b010; addr = 32'h80; start = 1;
    step();
    start = 0;
    chk("pre_rst_req", bus_req, 1);
    reset = 1;
    step();
    reset = 0;
    chk("rst_mid_req", {bus_req, busy}, 0);
    bus_ready = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst_no_done", {done, bus_req}, 0);
    end
    bus_ready = 0;
    for (int n = 0; n < 150; n++) begin
      bit [2:0] f3 = 3'($urandom);
      access(1'($urandom), f3, $urandom, $urandom, $urandom, $urandom_range(0, 4), $urandom_range(0, 15) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
